exec_unit: RTL and testbench
============================

# exec_unit

Sequential execute stage sitting directly downstream of the 16-entry register file. Consumes the accumulator (r15) and the selected operand register, computes one ALU operation per accepted command, and drives the register-file write port (`write_en` / `waddr` / `data_in`) to write the result back. Single-cycle ops complete in two cycles. An optional iterative shift-add multiplier writes a 2W-bit product to r15 (low) and r14 (high).

## Interface
Parameters:
- `W`, 8, data path width
- `D`, 4, register pointer width (register file depth 2**D)

Ports:
- `CLK` input 1: single clock, rising edge
- `RST_N` input 1: asynchronous, active-low reset
- `start` input 1: command strobe, sampled only in IDLE
- `op` input 4: opcode, sampled with `start`
- `rsel` input D: operand/destination register pointer; also drives register-file `raddr`
- `acc_in` input W: register-file accumulator output (r15)
- `reg_in` input W: register-file selected-register output
- `busy` output 1: high in every non-IDLE state
- `done` output 1: one-cycle pulse on a command's final cycle
- `write_en` output 1: register-file write enable
- `waddr` output D: register-file write pointer
- `data_out` output W: register-file write data
- `carry` output 1: carry/borrow flag
- `zero` output 1: zero flag

## Operation
- Operand capture: with `start`=1 in IDLE, latch `op`, `rsel`, `acc_in`, `reg_in`. Later operand changes have no effect.
- Opcodes, with acc = r15 and reg = r[rsel]:
  - 0 ADD: acc ← acc+reg; carry = bit W of the sum.
  - 1 SUB: acc ← acc−reg; carry = 1 when acc<reg (borrow).
  - 2 AND, 3 OR, 4 XOR: acc ← acc op reg; carry ← 0.
  - 5 SHL: acc ← acc<<1; carry = old bit W−1.
  - 6 SHR: logical acc>>1; carry = old bit 0.
  - 7 LDR: acc ← reg; carry unchanged.
  - 8 STR: r[rsel] ← acc; carry unchanged.
  - 9 MUL: {r14,r15} ← acc×reg, unsigned. Only with the macro defined; see Configuration.
  - 10–15 reserved: NOP.
- Flag updates:
  - `zero` = (written result == 0), updated in the write cycle.
  - For MUL, `zero` = (full 2W product == 0) and `carry` = (high half != 0). Both update in WB_HI.
  - NOP leaves both flags unchanged.
- States:
  - IDLE: on `start`, go to WB for single-cycle ops, MUL_IT for MUL, NOPC for NOP.
  - WB: write result, pulse `done`, go to IDLE.
  - NOPC: pulse `done` with no write, go to IDLE.
  - MUL_IT: W iterations, one partial-product add and shift per cycle, 2W-bit accumulator; then go to WB_LO.
  - WB_LO: write low half to waddr 15; no `done`.
  - WB_HI: write high half to waddr 14, pulse `done`, go to IDLE.
- STR with `rsel`=0: `write_en` is still asserted. The register file ignores address 0; `done` and flags behave normally.
- Reset: `RST_N` low forces, immediately, state=IDLE, all outputs 0, flags 0, multiplier state cleared. An in-flight command is abandoned with no further writes.

## Timing
- All outputs are registered.
- Cycle 0 is the edge where `start` is sampled.
- Single-cycle op: `busy`, `write_en` and `done` are high in cycle 1; back in IDLE in cycle 2. Throughput is one op per 2 cycles.
- NOP: `done` high in cycle 1, `write_en` 0.
- MUL: MUL_IT occupies cycles 1..W, WB_LO is cycle W+1, WB_HI/`done` is cycle W+2 (cycle 10 at W=8).
- `start` while `busy`=1 is ignored; no queuing.
- `start` in the same cycle as `done` is ignored, because the state is not yet IDLE.
- `write_en` is high only in WB, WB_LO and WB_HI. In those cycles `waddr`/`data_out` are valid; otherwise both are 0.
- A new `start` may be issued in the first IDLE cycle. It sees written-back values because register-file reads are combinational.

## Configuration
- `EXEC_MUL_EN` defined: opcode 9 runs the iterative multiplier exactly as above.
- `EXEC_MUL_EN` undefined:
  - The multiplier datapath and the MUL_IT/WB_LO/WB_HI states are not compiled.
  - Opcode 9 decodes as NOP: `done` in cycle 1, no write, flags unchanged.

## Test plan
- Reset: hold `RST_N`=0 mid-MUL (cycle 4) -> outputs/flags 0 at once; after release, `busy`=0 and no write to r14/r15 ever occurs.
- ADD overflow: acc=0xF0, reg=0x20, op=0 -> cycle 1: `write_en`=1, `waddr`=15, `data_out`=0x10, `carry`=1, `zero`=0, `done`=1.
- SUB equal and borrow: acc=0x33, reg=0x33 -> `data_out`=0x00, `zero`=1, `carry`=0. Then acc=0x01, reg=0x02 -> `data_out`=0xFF, `carry`=1.
- STR/ignored start: op=8, rsel=3, acc=0x5A -> cycle 1 write 0x5A to waddr 3. A `start` pulsed in cycle 1 produces no second command.
- MUL (`EXEC_MUL_EN`): acc=0xFF, reg=0xFF -> cycle 9 writes 0x01 to r15, cycle 10 writes 0xFE to r14 with `done`=1, `carry`=1, `zero`=0, `busy` high cycles 1–10.
- MUL disabled / reserved: op=9 without the macro, and op=12 -> `done` in cycle 1, `write_en`=0 throughout, flags unchanged.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: sequential execute stage behind the 16-entry register file.
//
// Captures the accumulator (r15) and a selected register on an accepted start.
// It runs one ALU operation and writes the result back through the register-file
// write port. Single-cycle ops write back in the cycle after start. All outputs
// are registered.
//
// Optional feature macro: EXEC_MUL_EN
//   Defined   - opcode 9 runs a W-cycle shift-add multiplier. The product low half
//               is written to r15 (WB_LO) and the high half to r14 (WB_HI).
//   Undefined - the multiplier is absent and opcode 9 behaves as a NOP.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   start    in   command strobe, honoured only in IDLE
//   op       in   opcode (4 bits), sampled with start
//   rsel     in   operand/destination register pointer (also register-file raddr)
//   acc_in   in   register-file r15 read data
//   reg_in   in   register-file r[rsel] read data
//   busy     out  high in every non-IDLE state
//   done     out  one-cycle pulse on a command's final cycle
//   write_en out  register-file write enable
//   waddr    out  register-file write pointer (0 when not writing)
//   data_out out  register-file write data (0 when not writing)
//   carry    out  carry/borrow flag
//   zero     out  zero flag
module exec_unit #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [D-1:0] rsel,
    input  logic [W-1:0] acc_in,
    input  logic [W-1:0] reg_in,
    output logic         busy,
    output logic         done,
    output logic         write_en,
    output logic [D-1:0] waddr,
    output logic [W-1:0] data_out,
    output logic         carry,
    output logic         zero
);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpShl = 4'd5;
    localparam logic [3:0] OpShr = 4'd6;
    localparam logic [3:0] OpLdr = 4'd7;
    localparam logic [3:0] OpStr = 4'd8;

    localparam logic [D-1:0] AccAddr = D'(15);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWb    = 3'd1,
        StNopc  = 3'd2
`ifdef EXEC_MUL_EN
        ,
        StMulIt = 3'd3,
        StWbLo  = 3'd4,
        StWbHi  = 3'd5
`endif
    } state_e;

    state_e         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           we_q, we_d;
    logic [D-1:0]   waddr_q, waddr_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;

    // ALU decode of the live inputs; only consumed on the accepting edge.
    logic [W:0]     ext_sum;
    logic [W:0]     ext_diff;
    logic [W-1:0]   alu_res;
    logic           alu_carry;
    logic [D-1:0]   alu_addr;
    logic           alu_wr;

    assign ext_sum  = {1'b0, acc_in} + {1'b0, reg_in};
    // Bit W of the widened difference is the borrow (acc < reg).
    assign ext_diff = {1'b0, acc_in} - {1'b0, reg_in};

    always_comb begin
        alu_res   = '0;
        alu_carry = carry_q;
        alu_addr  = AccAddr;
        alu_wr    = 1'b1;
        case (op)
            OpAdd: begin
                alu_res   = ext_sum[W-1:0];
                alu_carry = ext_sum[W];
            end
            OpSub: begin
                alu_res   = ext_diff[W-1:0];
                alu_carry = ext_diff[W];
            end
            OpAnd: begin
                alu_res   = acc_in & reg_in;
                alu_carry = 1'b0;
            end
            OpOr: begin
                alu_res   = acc_in | reg_in;
                alu_carry = 1'b0;
            end
            OpXor: begin
                alu_res   = acc_in ^ reg_in;
                alu_carry = 1'b0;
            end
            OpShl: begin
                alu_res   = {acc_in[W-2:0], 1'b0};
                alu_carry = acc_in[W-1];
            end
            OpShr: begin
                alu_res   = {1'b0, acc_in[W-1:1]};
                alu_carry = acc_in[0];
            end
            OpLdr: alu_res = reg_in;
            OpStr: begin
                alu_res  = acc_in;
                alu_addr = rsel;
            end
            // Reserved codes (and MUL when the multiplier is absent) complete as NOPs.
            default: alu_wr = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam logic [3:0]  OpMul  = 4'd9;
    localparam logic [D-1:0] HiAddr = D'(14);
    localparam int unsigned CntW   = $clog2(W + 1);
    localparam logic [CntW-1:0] LastIt = CntW'(W - 1);

    logic [W-1:0]    mcand_q, mcand_d;
    logic [2*W-1:0]  prod_q, prod_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W:0]      part_sum;
    logic [2*W-1:0]  prod_step;

    // prod_q holds {partial high, unconsumed multiplier bits}; each step adds the
    // multiplicand into the high half when the LSB is set, then shifts right.
    assign part_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {part_sum, prod_q[W-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        waddr_d = '0;
        dout_d  = '0;
        carry_d = carry_q;
        zero_d  = zero_q;
`ifdef EXEC_MUL_EN
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d = 1'b1;
`ifdef EXEC_MUL_EN
                    if (op == OpMul) begin
                        state_d = StMulIt;
                        mcand_d = acc_in;
                        prod_d  = {{W{1'b0}}, reg_in};
                        cnt_d   = '0;
                    end else
`endif
                    if (alu_wr) begin
                        state_d = StWb;
                        done_d  = 1'b1;
                        we_d    = 1'b1;
                        waddr_d = alu_addr;
                        dout_d  = alu_res;
                        carry_d = alu_carry;
                        zero_d  = (alu_res == '0);
                    end else begin
                        state_d = StNopc;
                        done_d  = 1'b1;
                    end
                end
            end
            StWb, StNopc: state_d = StIdle;
`ifdef EXEC_MUL_EN
            StMulIt: begin
                busy_d = 1'b1;
                prod_d = prod_step;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastIt) begin
                    state_d = StWbLo;
                    we_d    = 1'b1;
                    waddr_d = AccAddr;
                    dout_d  = prod_step[W-1:0];
                end
            end
            StWbLo: begin
                state_d = StWbHi;
                busy_d  = 1'b1;
                done_d  = 1'b1;
                we_d    = 1'b1;
                waddr_d = HiAddr;
                dout_d  = prod_q[2*W-1:W];
                carry_d = |prod_q[2*W-1:W];
                zero_d  = (prod_q == '0);
            end
            StWbHi: state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs are loaded with the values for the state being entered, so each
    // output is a plain register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            dout_q  <= dout_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

`ifdef EXEC_MUL_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign write_en = we_q;
    assign waddr    = waddr_q;
    assign data_out = dout_q;
    assign carry    = carry_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a scoreboard of expected write/done events.
module tb_exec_unit;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [D-1:0] rsel = '0;
    logic [W-1:0] acc_in = '0;
    logic [W-1:0] reg_in = '0;
    logic         busy;
    logic         done;
    logic         write_en;
    logic [D-1:0] waddr;
    logic [W-1:0] data_out;
    logic         carry;
    logic         zero;

    exec_unit #(.W(W), .D(D)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .op       (op),
        .rsel     (rsel),
        .acc_in   (acc_in),
        .reg_in   (reg_in),
        .busy     (busy),
        .done     (done),
        .write_en (write_en),
        .waddr    (waddr),
        .data_out (data_out),
        .carry    (carry),
        .zero     (zero)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Expected event: {cycle[31:0], write_en, waddr[3:0], data[7:0], done, carry, zero}
    typedef struct {
        string       tag;
        logic [47:0] v;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic exp_carry = 1'b0;
    logic exp_zero  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic push_ev(input string tag, input int c, input logic we, input logic [3:0] a,
                           input logic [7:0] d, input logic dn);
        exp_t e;
        e.tag = tag;
        e.v   = {32'(c), we, a, d, dn, exp_carry, exp_zero};
        sb.push_back(e);
    endtask

    // Reference model: push the events a command issued while cyc == c0 should produce.
    task automatic expect_cmd(input string tag, input int c0, input logic [3:0] o,
                              input logic [3:0] rs, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [7:0]  res;
        logic [3:0]  addr;
        logic [15:0] p;
        bit          wr;
        bit          mul;
        s    = '0;
        res  = '0;
        addr = 4'd15;
        p    = '0;
        wr   = 1'b1;
        mul  = 1'b0;
        case (o)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; res = s[7:0]; exp_carry = s[8]; end
            4'd1: begin res = a - b; exp_carry = (a < b); end
            4'd2: begin res = a & b; exp_carry = 1'b0; end
            4'd3: begin res = a | b; exp_carry = 1'b0; end
            4'd4: begin res = a ^ b; exp_carry = 1'b0; end
            4'd5: begin res = {a[6:0], 1'b0}; exp_carry = a[7]; end
            4'd6: begin res = {1'b0, a[7:1]}; exp_carry = a[0]; end
            4'd7: res = b;
            4'd8: begin res = a; addr = rs; end
`ifdef EXEC_MUL_EN
            4'd9: mul = 1'b1;
`endif
            default: wr = 1'b0;
        endcase
        if (mul) begin
            p = {8'h00, a} * {8'h00, b};
            push_ev({tag, "_lo"}, c0 + W + 1, 1'b1, 4'd15, p[7:0], 1'b0);
            exp_carry = (p[15:8] != 8'h00);
            exp_zero  = (p == 16'h0000);
            push_ev({tag, "_hi"}, c0 + W + 2, 1'b1, 4'd14, p[15:8], 1'b1);
        end else if (wr) begin
            exp_zero = (res == 8'h00);
            push_ev(tag, c0 + 1, 1'b1, addr, res, 1'b1);
        end else begin
            push_ev(tag, c0 + 1, 1'b0, 4'd0, 8'h00, 1'b1);
        end
    endtask

    // Drive one start pulse; returns #1 after the accepting edge (cycle 1).
    task automatic issue(input string tag, input logic [3:0] o, input logic [3:0] rs,
                         input logic [7:0] a, input logic [7:0] b, input bit push);
        if (push) expect_cmd(tag, cyc, o, rs, a, b);
        op     = o;
        rsel   = rs;
        acc_in = a;
        reg_in = b;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        start  = 1'b0;
        // Operands must already be captured.
        op     = 4'($urandom);
        rsel   = 4'($urandom);
        acc_in = 8'($urandom);
        reg_in = 8'($urandom);
    endtask

    // From cycle 1, count negedges until busy drops; ends in the first IDLE cycle.
    task automatic wait_idle(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < 60);
        check(tag, 64'(n), 64'(exp_n));
    endtask

    always @(negedge CLK) begin
        if (RST_N && (write_en || done)) begin
            check("unexpected_output", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check(mon_e.tag,
                      {16'h0, 32'(cyc), write_en, waddr, data_out, done, carry, zero},
                      {16'h0, mon_e.v});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic quiet;

        // Reset state
        @(posedge CLK);
        #1;
        check("reset_state", 64'({busy, done, write_en, waddr, data_out, carry, zero}), 64'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);

        // Single-cycle arithmetic with overflow, equality and borrow
        issue("add_ovf", 4'd0, 4'd2, 8'hF0, 8'h20, 1'b1);
        wait_idle("add_ovf_busy", 2);
        issue("sub_eq", 4'd1, 4'd2, 8'h33, 8'h33, 1'b1);
        wait_idle("sub_eq_busy", 2);
        issue("sub_borrow", 4'd1, 4'd2, 8'h01, 8'h02, 1'b1);
        wait_idle("sub_borrow_busy", 2);

        // Asynchronous reset in flight (flags are nonzero here: carry = 1)
`ifdef EXEC_MUL_EN
        issue("mul_abort", 4'd9, 4'd1, 8'h37, 8'h5C, 1'b0);
        repeat (3) @(posedge CLK);
`else
        issue("add_abort", 4'd0, 4'd1, 8'h37, 8'h5C, 1'b0);
`endif
        #2;
        check("abort_busy_before", 64'(busy), 64'd1);
        RST_N = 1'b0;
        #1;
        check("abort_outputs_zero",
              64'({busy, done, write_en, waddr, data_out, carry, zero}), 64'd0);
        exp_carry = 1'b0;
        exp_zero  = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        quiet = 1'b0;
        repeat (14) begin
            @(negedge CLK);
            quiet = quiet | busy | write_en;
        end
        check("abort_no_activity", 64'(quiet), 64'd0);

        // STR to r3 with a start held into cycle 1, which must be ignored
        expect_cmd("str_r3", cyc, 4'd8, 4'd3, 8'h5A, 8'h11);
        op     = 4'd8;
        rsel   = 4'd3;
        acc_in = 8'h5A;
        reg_in = 8'h11;
        start  = 1'b1;
        @(posedge CLK);
        #1;
        op     = 4'd0;
        acc_in = 8'h01;
        reg_in = 8'h01;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(negedge CLK);
        check("str_ignored_start", 64'(busy), 64'd0);

        // STR to r0 still asserts write_en
        issue("str_r0", 4'd8, 4'd0, 8'h00, 8'h99, 1'b1);
        wait_idle("str_r0_busy", 2);

        // Logic and shift ops
        issue("and", 4'd2, 4'd4, 8'hA5, 8'h3C, 1'b1);
        wait_idle("and_busy", 2);
        issue("or", 4'd3, 4'd4, 8'h0F, 8'hF0, 1'b1);
        wait_idle("or_busy", 2);
        issue("xor_zero", 4'd4, 4'd4, 8'h55, 8'h55, 1'b1);
        wait_idle("xor_busy", 2);
        issue("shl", 4'd5, 4'd4, 8'h81, 8'h00, 1'b1);
        wait_idle("shl_busy", 2);
        issue("shr", 4'd6, 4'd4, 8'h01, 8'hFF, 1'b1);
        wait_idle("shr_busy", 2);
        issue("ldr_keep_carry", 4'd7, 4'd5, 8'h00, 8'h7E, 1'b1);
        wait_idle("ldr_busy", 2);

        // Reserved opcode and opcode 9
        issue("nop_12", 4'd12, 4'd6, 8'h12, 8'h34, 1'b1);
        wait_idle("nop_12_busy", 2);
`ifdef EXEC_MUL_EN
        issue("mul_ffff", 4'd9, 4'd6, 8'hFF, 8'hFF, 1'b1);
        wait_idle("mul_ffff_busy", W + 3);
        issue("mul_zero", 4'd9, 4'd6, 8'h00, 8'h37, 1'b1);
        wait_idle("mul_zero_busy", W + 3);
        issue("mul_1010", 4'd9, 4'd6, 8'h10, 8'h10, 1'b1);
        wait_idle("mul_1010_busy", W + 3);
`else
        issue("op9_nop", 4'd9, 4'd6, 8'hFF, 8'hFF, 1'b1);
        wait_idle("op9_nop_busy", 2);
`endif

        // Back-to-back commands issued in the first IDLE cycle
        issue("b2b_add", 4'd0, 4'd7, 8'h80, 8'h80, 1'b1);
        wait_idle("b2b_add_busy", 2);
        issue("b2b_sub", 4'd1, 4'd7, 8'h10, 8'h01, 1'b1);
        wait_idle("b2b_sub_busy", 2);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
